// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module : rv32i_pkg
// Brief  : Shared opcode, ALU-op, jump-select and immediate-format definitions.
// Rev    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_NORMAL = 2'b10;
  localparam logic [1:0] ALUOP_ALT    = 2'b11;

  localparam logic [1:0] JF_NONE  = 2'b00;
  localparam logic [1:0] JF_JAL   = 2'b01;
  localparam logic [1:0] JF_JALR  = 2'b10;
  localparam logic [1:0] JF_AUIPC = 2'b11;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  alu_ctrl;
    logic [1:0]  alu_op;
    logic        reg_w;
    logic        data_b_sel;
    logic        pc_add_sel;
    logic        w_data_sel;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  jf;
    logic [31:0] imm;
  } dec_out_t;

endpackage
`default_nettype wire

// File: rtl/rv32i_imm_gen.sv
`default_nettype none
// ============================================================================
// Module : rv32i_imm_gen
// Brief  : Combinational sign-extended immediate builder for all RV32I formats.
// Rev    : 1.0 - initial release
// ============================================================================
module rv32i_imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:7] inst_i,
  input  imm_fmt_e    fmt_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (fmt_i)
      IMM_I: imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S: imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B: imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                      inst_i[11:8], 1'b0};
      IMM_U: imm_o = {inst_i[31:12], 12'b0};
      IMM_J: imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                      inst_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv32i_decoder.sv
`default_nettype none
// ============================================================================
// Module : rv32i_decoder
// Brief  : RV32I decode stage; opcode decode plus a one-cycle output register.
// Rev    : 1.0 - initial release
// ============================================================================
module rv32i_decoder
  import rv32i_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] inst_i,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [2:0]  alu_ctrl_o,
  output logic [1:0]  alu_op_o,
  output logic        reg_w_ctrl_o,
  output logic        alu_dataB_sel_o,
  output logic        pc_add_sel_o,
  output logic        reg_w_data_sel_o,
  output logic        mem_read_ctrl_o,
  output logic        mem_write_ctrl_o,
  output logic [1:0]  jal_or_jalrF_o,
  output logic [31:0] imm_exten_o
);

  imm_fmt_e    imm_fmt;
  logic [31:0] imm_val;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  dec_out_t    dec_d;
  dec_out_t    dec_q;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];

  rv32i_imm_gen u_imm_gen (
    .inst_i (inst_i[31:7]),
    .fmt_i  (imm_fmt),
    .imm_o  (imm_val)
  );

  always_comb begin
    dec_d     = '0;
    imm_fmt   = IMM_NONE;
    dec_d.rs1 = inst_i[19:15];
    dec_d.rs2 = inst_i[24:20];
    dec_d.rd  = inst_i[11:7];
    case (opcode)
      OPC_OP: begin
        dec_d.alu_op     = inst_i[30] ? ALUOP_ALT : ALUOP_NORMAL;
        dec_d.alu_ctrl   = funct3;
        dec_d.reg_w      = 1'b1;
        dec_d.w_data_sel = 1'b1;
      end
      OPC_OPIMM: begin
        // Only SRAI uses inst[30] as an opcode bit; elsewhere it is immediate data.
        dec_d.alu_op     = (funct3 == 3'b101 && inst_i[30]) ? ALUOP_ALT : ALUOP_NORMAL;
        dec_d.alu_ctrl   = funct3;
        dec_d.reg_w      = 1'b1;
        dec_d.data_b_sel = 1'b1;
        dec_d.w_data_sel = 1'b1;
        imm_fmt          = IMM_I;
      end
      OPC_LOAD: begin
        dec_d.reg_w      = 1'b1;
        dec_d.data_b_sel = 1'b1;
        dec_d.mem_read   = 1'b1;
        imm_fmt          = IMM_I;
      end
      OPC_STORE: begin
        dec_d.data_b_sel = 1'b1;
        dec_d.mem_write  = 1'b1;
        imm_fmt          = IMM_S;
      end
      OPC_BRANCH: begin
        dec_d.alu_op     = ALUOP_BRANCH;
        dec_d.alu_ctrl   = funct3;
        dec_d.pc_add_sel = 1'b1;
        imm_fmt          = IMM_B;
      end
      OPC_JAL: begin
        dec_d.jf         = JF_JAL;
        dec_d.pc_add_sel = 1'b1;
        dec_d.reg_w      = 1'b1;
        dec_d.data_b_sel = 1'b1;
        dec_d.w_data_sel = 1'b1;
        imm_fmt          = IMM_J;
      end
      OPC_JALR: begin
        dec_d.jf         = JF_JALR;
        dec_d.pc_add_sel = 1'b1;
        dec_d.reg_w      = 1'b1;
        dec_d.data_b_sel = 1'b1;
        dec_d.w_data_sel = 1'b1;
        imm_fmt          = IMM_I;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_d.rs1        = '0;
        dec_d.reg_w      = 1'b1;
        dec_d.data_b_sel = 1'b1;
        dec_d.w_data_sel = 1'b1;
        dec_d.jf         = (opcode == OPC_AUIPC) ? JF_AUIPC : JF_NONE;
        imm_fmt          = IMM_U;
      end
      default: ;
    endcase
    if (dec_d.rd == 5'd0) dec_d.reg_w = 1'b0;
    dec_d.imm = imm_val;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) dec_q <= '0;
    else         dec_q <= dec_d;
  end

  assign rs1_o            = dec_q.rs1;
  assign rs2_o            = dec_q.rs2;
  assign rd_o             = dec_q.rd;
  assign alu_ctrl_o       = dec_q.alu_ctrl;
  assign alu_op_o         = dec_q.alu_op;
  assign reg_w_ctrl_o     = dec_q.reg_w;
  assign alu_dataB_sel_o  = dec_q.data_b_sel;
  assign pc_add_sel_o     = dec_q.pc_add_sel;
  assign reg_w_data_sel_o = dec_q.w_data_sel;
  assign mem_read_ctrl_o  = dec_q.mem_read;
  assign mem_write_ctrl_o = dec_q.mem_write;
  assign jal_or_jalrF_o   = dec_q.jf;
  assign imm_exten_o      = dec_q.imm;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_rv32i_decoder
// Brief  : Directed-vector self-checking bench for rv32i_decoder.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_rv32i_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  alu_ctrl;
  logic [1:0]  alu_op, jf;
  logic        rw, dbs, pcs, wds, mr, mw;
  logic [31:0] imm;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  rv32i_decoder dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .inst_i           (inst),
    .rs1_o            (rs1),
    .rs2_o            (rs2),
    .rd_o             (rd),
    .alu_ctrl_o       (alu_ctrl),
    .alu_op_o         (alu_op),
    .reg_w_ctrl_o     (rw),
    .alu_dataB_sel_o  (dbs),
    .pc_add_sel_o     (pcs),
    .reg_w_data_sel_o (wds),
    .mem_read_ctrl_o  (mr),
    .mem_write_ctrl_o (mw),
    .jal_or_jalrF_o   (jf),
    .imm_exten_o      (imm)
  );

  // Control bundle order: rs1 rs2 rd alu_ctrl alu_op rw dB pc wds mr mw jf
  function automatic logic [31:0] ctl_pack(input logic [4:0] a, b, c,
                                           input logic [2:0] f3, input logic [1:0] op,
                                           input logic w, d, p, s, r, m,
                                           input logic [1:0] j);
    return {4'b0, a, b, c, f3, op, w, d, p, s, r, m, j};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_ctl();
    return ctl_pack(rs1, rs2, rd, alu_ctrl, alu_op, rw, dbs, pcs, wds, mr, mw, jf);
  endfunction

  task automatic apply(input string tag, input logic [31:0] word, input logic [31:0] exp_ctl,
                       input logic [31:0] exp_imm);
    @(negedge clk);
    inst = word;
    @(posedge clk);
    #1;
    chk({tag, ".ctl"}, dut_ctl(), exp_ctl);
    chk({tag, ".imm"}, imm, exp_imm);
  endtask

  initial begin
    reset = 1'b1;
    inst  = 32'h0000_0C67;
    #10;
    chk("reset.ctl", dut_ctl(), 32'h0);
    chk("reset.imm", imm, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("jalr.ctl", dut_ctl(), ctl_pack(5'd0, 5'd0, 5'd24, 3'b000, 2'b00, 1, 1, 1, 1, 0, 0, 2'b10));
    chk("jalr.imm", imm, 32'h0);

    apply("add",   32'h00A5_8633, ctl_pack(5'd11, 5'd10, 5'd12, 3'b000, 2'b10, 1, 0, 0, 1, 0, 0, 2'b00), 32'h0);
    apply("sub",   32'h4031_00B3, ctl_pack(5'd2,  5'd3,  5'd1,  3'b000, 2'b11, 1, 0, 0, 1, 0, 0, 2'b00), 32'h0);
    apply("add0",  32'h00A5_8033, ctl_pack(5'd11, 5'd10, 5'd0,  3'b000, 2'b10, 0, 0, 0, 1, 0, 0, 2'b00), 32'h0);
    apply("lw",    32'hFFC3_2283, ctl_pack(5'd6,  5'd28, 5'd5,  3'b000, 2'b00, 1, 1, 0, 0, 1, 0, 2'b00), 32'hFFFF_FFFC);
    apply("sw",    32'h0071_2423, ctl_pack(5'd2,  5'd7,  5'd8,  3'b000, 2'b00, 0, 1, 0, 0, 0, 1, 2'b00), 32'h0000_0008);
    apply("swneg", 32'hFE71_2E23, ctl_pack(5'd2,  5'd7,  5'd28, 3'b000, 2'b00, 0, 1, 0, 0, 0, 1, 2'b00), 32'hFFFF_FFFC);
    apply("beq",   32'hFE20_8CE3, ctl_pack(5'd1,  5'd2,  5'd25, 3'b000, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00), 32'hFFFF_FFF8);
    apply("srai",  32'h4033_5293, ctl_pack(5'd6,  5'd3,  5'd5,  3'b101, 2'b11, 1, 1, 0, 1, 0, 0, 2'b00), 32'h0000_0403);
    apply("addi",  32'h4000_0093, ctl_pack(5'd0,  5'd0,  5'd1,  3'b000, 2'b10, 1, 1, 0, 1, 0, 0, 2'b00), 32'h0000_0400);
    apply("lui",   32'h1234_51B7, ctl_pack(5'd0,  5'd3,  5'd3,  3'b000, 2'b00, 1, 1, 0, 1, 0, 0, 2'b00), 32'h1234_5000);
    apply("auipc", 32'h1234_5197, ctl_pack(5'd0,  5'd3,  5'd3,  3'b000, 2'b00, 1, 1, 0, 1, 0, 0, 2'b11), 32'h1234_5000);
    apply("jal",   32'h0080_00EF, ctl_pack(5'd0,  5'd8,  5'd1,  3'b000, 2'b00, 1, 1, 1, 1, 0, 0, 2'b01), 32'h0000_0008);
    apply("jalneg",32'hFFDF_F06F, ctl_pack(5'd31, 5'd29, 5'd0,  3'b000, 2'b00, 0, 1, 1, 1, 0, 0, 2'b01), 32'hFFFF_FFFC);

    // New input must not show through before the next edge.
    apply("hold0", 32'h00A5_8633, ctl_pack(5'd11, 5'd10, 5'd12, 3'b000, 2'b10, 1, 0, 0, 1, 0, 0, 2'b00), 32'h0);
    @(negedge clk);
    inst = 32'hFFC3_2283;
    #1;
    chk("hold.ctl", dut_ctl(), ctl_pack(5'd11, 5'd10, 5'd12, 3'b000, 2'b10, 1, 0, 0, 1, 0, 0, 2'b00));

    // Asynchronous clear between edges.
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("areset.ctl", dut_ctl(), 32'h0);
    chk("areset.imm", imm, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    apply("illegal", 32'h0000_007F, 32'h0, 32'h0);
    apply("illraw",  32'hFFFF_FFFF, ctl_pack(5'd31, 5'd31, 5'd31, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
